count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_checker.sv | 127 ++++++++++++
 tb/tb_count_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// Watches an up-counter and locks once LOCK_N consecutive +1 steps are seen.
// While locked, any out-of-sequence sample raises a one-cycle error pulse and drops lock.
module count_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_N     = 4,
  parameter int CNT_W      = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK_V = 4'(LOCK_N);
  localparam logic             HOLD_V = (ALLOW_HOLD != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             valid_q, valid_d;
  logic [3:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] wrap_q, wrap_d;
  logic             err_inc_s, wrap_inc_s;
  logic [WIDTH-1:0] expected_s;

  // Sequence tracking and statistics next-state
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    locked_d   = locked_q;
    error_d    = 1'b0;
    err_inc_s  = 1'b0;
    wrap_inc_s = 1'b0;
    prev_d     = count;
    valid_d    = 1'b1;
    expected_s = prev_q + WIDTH'(1);
    if (valid_q) begin
      case (state_q)
        UNLOCKED: begin
          if (count == expected_s) begin
            if ((run_q + 4'd1) == LOCK_V) begin
              state_d  = LOCKED;
              run_d    = 4'd0;
              locked_d = 1'b1;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        LOCKED: begin
          if (count == expected_s) begin
            wrap_inc_s = (prev_q == MAX_V);
          end else if (HOLD_V && (count == prev_q)) begin
            wrap_inc_s = 1'b0;
          end else begin
            error_d   = 1'b1;
            err_inc_s = 1'b1;
            state_d   = UNLOCKED;
            locked_d  = 1'b0;
            run_d     = 4'd0;
          end
        end
        default: begin
          state_d  = UNLOCKED;
          locked_d = 1'b0;
          run_d    = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // A coincident event survives a clear as a count of one
    if (clear) begin
      err_d  = err_inc_s  ? CNT_W'(1) : {CNT_W{1'b0}};
      wrap_d = wrap_inc_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else begin
      err_d  = err_inc_s  ? sat_inc(err_q)  : err_q;
      wrap_d = wrap_inc_s ? sat_inc(wrap_q) : wrap_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      prev_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
      run_q    <= 4'd0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= {CNT_W{1'b0}};
      wrap_q   <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      valid_q  <= valid_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
    end
  end

  assign locked     = locked_q;
  assign error      = error_q;
  assign err_count  = err_q;
  assign wrap_count = wrap_q;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench: two checker instances (strict with 2-bit counters, hold-tolerant
// with 8-bit counters) share one randomized count stream and a behavioural model.
module tb_count_checker;

  localparam int LOCK_N = 4;

  typedef struct packed {
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic [7:0] wc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count = 4'd0;
  logic       clear = 1'b0;
  logic       lk0, er0, lk1, er1;
  logic [1:0] ec0, wc0;
  logic [7:0] ec1, wc1;

  int n_checks = 0;
  int n_errors = 0;
  int cur = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_have[2], m_last[2], m_lock[2], m_run[2], m_errc[2], m_wrapc[2];
  int p_hold[2] = '{0, 1};
  int p_cmax[2] = '{3, 255};

  count_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .CNT_W(2), .ALLOW_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .count(count), .clear(clear),
    .locked(lk0), .error(er0), .err_count(ec0), .wrap_count(wc0));

  count_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .CNT_W(8), .ALLOW_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .count(count), .clear(clear),
    .locked(lk1), .error(er1), .err_count(ec1), .wrap_count(wc1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap(input int d);
    exp_t e;
    e.lk = 1'(m_lock[d]);
    e.er = 1'b0;
    e.ec = 8'(m_errc[d]);
    e.wc = 8'(m_wrapc[d]);
    return e;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_have[d] = 0; m_last[d] = 0; m_lock[d] = 0;
      m_run[d] = 0; m_errc[d] = 0; m_wrapc[d] = 0;
    end
  endtask

  task automatic push_zero();
    exp_t z;
    z = '0;
    q0.push_back(z);
    q1.push_back(z);
  endtask

  // Reference behaviour for one sampled value on both instances
  task automatic model_step(input int c, input bit clr);
    for (int d = 0; d < 2; d++) begin
      bit   err;
      bit   wr;
      exp_t e;
      err = 1'b0;
      wr  = 1'b0;
      if (m_have[d] != 0) begin
        if (c == (m_last[d] + 1) % 16) begin
          if (m_lock[d] != 0) begin
            wr = (c == 0);
          end else begin
            m_run[d]++;
            if (m_run[d] == LOCK_N) begin
              m_lock[d] = 1;
              m_run[d]  = 0;
            end
          end
        end else if (m_lock[d] != 0 && p_hold[d] != 0 && c == m_last[d]) begin
          wr = 1'b0;
        end else begin
          err       = (m_lock[d] != 0);
          m_lock[d] = 0;
          m_run[d]  = 0;
        end
      end
      if (clr) begin
        m_errc[d]  = 0;
        m_wrapc[d] = 0;
      end
      if (err) m_errc[d] = (m_errc[d] + 1 > p_cmax[d]) ? p_cmax[d] : m_errc[d] + 1;
      if (wr) m_wrapc[d] = (m_wrapc[d] + 1 > p_cmax[d]) ? p_cmax[d] : m_wrapc[d] + 1;
      m_last[d] = c;
      m_have[d] = 1;
      e = snap(d);
      e.er = err;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic step(input int c, input bit clr);
    @(negedge clk);
    count = 4'(c);
    clear = clr;
    cur   = c;
    model_step(c, clr);
  endtask

  task automatic inc_step(input bit clr);
    step((cur + 1) % 16, clr);
  endtask

  task automatic bad_step(input bit clr);
    step((cur + 3) % 16, clr);
  endtask

  // Reset held 15 ns spanning two edges; outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_locked0", lk0, 0);
    chk("rst_async_error0", er0, 0);
    chk("rst_async_errc0", ec0, 0);
    chk("rst_async_wrapc0", wc0, 0);
    chk("rst_async_locked1", lk1, 0);
    chk("rst_async_error1", er1, 0);
    chk("rst_async_errc1", ec1, 0);
    chk("rst_async_wrapc1", wc1, 0);
    model_reset();
    push_zero();
    @(negedge clk);
    push_zero();
    #7 reset = 1'b0;
  endtask

  // Monitor: every clock edge the checkers present a fresh output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_locked", lk0, e.lk);
        chk("d0_error", er0, e.er);
        chk("d0_err_count", ec0, e.ec);
        chk("d0_wrap_count", wc0, e.wc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_locked", lk1, e.lk);
        chk("d1_error", er1, e.er);
        chk("d1_err_count", ec1, e.ec);
        chk("d1_wrap_count", wc1, e.wc);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    for (int i = 0; i <= 15; i++) step(i, 1'b0);
    step(0, 1'b0);
    step(1, 1'b0);
    for (int i = 2; i <= 6; i++) step(i, 1'b0);
    step(9, 1'b0);
    for (int i = 10; i <= 15; i++) step(i, 1'b0);
    for (int i = 0; i <= 7; i++) step(i, 1'b0);
    step(7, 1'b0);
    for (int i = 8; i <= 12; i++) step(i, 1'b0);

    // Drive the 2-bit error counter into saturation
    for (int k = 0; k < 5; k++) begin
      bad_step(1'b0);
      for (int j = 0; j < LOCK_N; j++) inc_step(1'b0);
    end
    inc_step(1'b1);
    inc_step(1'b0);
    bad_step(1'b1);
    for (int j = 0; j < LOCK_N; j++) inc_step(1'b0);
    while (cur != 15) inc_step(1'b0);
    step(0, 1'b1);
    inc_step(1'b0);
    bad_step(1'b0);
    for (int j = 0; j < LOCK_N; j++) inc_step(1'b0);
    bad_step(1'b0);
    for (int j = 0; j < LOCK_N; j++) inc_step(1'b0);
    bad_step(1'b0);
    do_reset();
    for (int j = 0; j < LOCK_N + 3; j++) inc_step(1'b0);
    do_reset();

    for (int n = 0; n < 600; n++) begin
      int r;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 249) == 0) do_reset();
      else if (r < 82) inc_step(c);
      else if (r < 91) step(cur, c);
      else step($urandom_range(0, 15), c);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
